// File: rtl/seq_det_pkg.sv
// Shared types and default pattern constants for the serial pattern sequencer.
package seq_det_pkg;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, REPORT} seq_state_e;

  localparam int             DEF_PAT_W = 3;
  localparam logic [2:0]     DEF_PAT   = 3'b101;

endpackage

// File: rtl/seq_det_core.sv
// Serial pattern detector: sliding window, fill counter and registered hit flag.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int               PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT   = DEF_PAT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  next_win;
  logic [FILL_W-1:0] fill;

  // NOTE: combinational block assigns its output on every path, so no latch is inferred.
  always_comb begin
    next_win = {window[PAT_W-2:0], bit_in};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      window <= '0;
      fill   <= '0;
      hit    <= 1'b0;
    end else if (en) begin
      window <= next_win;
      if (fill != FILL_W'(PAT_W))
        fill <= fill + FILL_W'(1);
      // Fill of PAT_W-1 before this bit means the window is full after it.
      hit <= (next_win == PAT) && (fill >= FILL_W'(PAT_W - 1));
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_frame_ctrl.sv
// Word sequencer: shifts each accepted word MSB-first through the detector and reports per-word hits.
module seq_frame_ctrl
  import seq_det_pkg::*;
#(
  parameter int               WORD_W = 8,
  parameter int               PAT_W  = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT    = DEF_PAT,
  parameter int               CNT_W  = 4,
  localparam int              IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_clr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_found,
  output logic [IDX_W-1:0]  res_first_idx,
  output logic              busy
);

  localparam logic [IDX_W:0]   K_LAST  = (IDX_W + 1)'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e        state;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W:0]    k;
  logic [IDX_W:0]    k_prev;
  logic              hit;

  assign k_prev = k - (IDX_W + 1)'(1);

  seq_det_core #(.PAT_W(PAT_W), .PAT(PAT)) u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == CLR),
    .en     (state == SHIFT),
    .bit_in (shreg[WORD_W-1]),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      k             <= '0;
      in_ready      <= 1'b1;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_count     <= '0;
      res_found     <= 1'b0;
      res_first_idx <= '0;
    end else begin
      // A hit seen now was completed by the bit shifted in the previous cycle.
      if (((state == SHIFT) && (k != '0)) || (state == DRAIN)) begin
        if (hit) begin
          if (res_count != CNT_MAX)
            res_count <= res_count + CNT_W'(1);
          if (!res_found) begin
            res_found     <= 1'b1;
            res_first_idx <= k_prev[IDX_W-1:0];
          end
        end
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg         <= in_word;
            k             <= '0;
            res_count     <= '0;
            res_found     <= 1'b0;
            res_first_idx <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b1;
            state         <= in_clr ? CLR : SHIFT;
          end
        end
        CLR: state <= SHIFT;
        SHIFT: begin
          shreg <= shreg << 1;
          k     <= k + (IDX_W + 1)'(1);
          if (k == K_LAST)
            state <= DRAIN;
        end
        DRAIN: begin
          res_valid <= 1'b1;
          state     <= REPORT;
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
